// File: rtl/div_pkg.sv
// div_pkg: shared width, FSM states and constants for the divider scheduler
package div_pkg;
    localparam int DIV_W = 32;
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    typedef logic port_t;
    localparam logic [DIV_W-1:0] DIV0_QUO = '1;
endpackage

// File: rtl/div_iter_u.sv
// div_iter_u: restoring unsigned divider, one quotient bit per cycle
module div_iter_u
    import div_pkg::*;
#(parameter int WIDTH = DIV_W)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dnd,
    input  logic [WIDTH-1:0] der,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   t;
    logic             ge;
    // partial remainder shifted left with the next dividend bit; t < 2*d so the low bits minus d cannot wrap
    always_comb begin
        t    = {rem, quo[WIDTH-1]};
        ge   = t[WIDTH] || (t[WIDTH-1:0] >= d);
        done = busy && (cnt == CW'(1));
    end
    // load operands on start, then shift/subtract until the last bit is produced
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            d    <= '0;
            quo  <= '0;
            rem  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(WIDTH);
            d    <= der;
            quo  <= dnd;
            rem  <= '0;
        end else if (busy) begin
            quo  <= {quo[WIDTH-2:0], ge};
            rem  <= ge ? t[WIDTH-1:0] - d : t[WIDTH-1:0];
            cnt  <= cnt - CW'(1);
            busy <= !done;
        end
    end
endmodule

// File: rtl/div_sched.sv
// div_sched: round-robin front end for a shared divider with sign and divide-by-zero fix-up
module div_sched
    import div_pkg::*;
#(parameter int WIDTH = DIV_W)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             sgn0,
    input  logic             sgn1,
    input  logic [WIDTH-1:0] dnd0,
    input  logic [WIDTH-1:0] dnd1,
    input  logic [WIDTH-1:0] der0,
    input  logic [WIDTH-1:0] der1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             err,
    output logic             busy
);
    state_t           state, nxt;
    port_t            lst, g, pid;
    logic             go, s, nq, nr, zf, cbusy, cdone;
    logic [WIDTH-1:0] a, b, am, bm, raw, cq, cr;
    // grant selection, operand magnitudes, ack pulses and next state
    always_comb begin
        g    = (req0 && req1) ? ~lst : req1;
        s    = g ? sgn1 : sgn0;
        a    = g ? dnd1 : dnd0;
        b    = g ? der1 : der0;
        am   = (s && a[WIDTH-1]) ? -a : a;
        bm   = (s && b[WIDTH-1]) ? -b : b;
        go   = (state == IDLE) && (req0 || req1);
        ack0 = go && !g;
        ack1 = go && g;
        nxt  = go ? ((|b) ? RUN : FIX) :
               (state == RUN && cdone) ? FIX :
               (state == FIX) ? IDLE : state;
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    // latch the granted request, then apply sign and zero fix-ups to the core result
    always_ff @(posedge clk) begin
        if (rst) begin
            lst   <= 1'b1;
            pid   <= 1'b0;
            nq    <= 1'b0;
            nr    <= 1'b0;
            zf    <= 1'b0;
            raw   <= '0;
            quo   <= '0;
            rem   <= '0;
            err   <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
        end else begin
            done0 <= (state == FIX) && !pid;
            done1 <= (state == FIX) && pid;
            if (go) begin
                lst <= g;
                pid <= g;
                nq  <= s && (a[WIDTH-1] ^ b[WIDTH-1]);
                nr  <= s && a[WIDTH-1];
                zf  <= ~|b;
                raw <= a;
            end
            if (state == FIX) begin
                quo <= zf ? {WIDTH{DIV0_QUO[0]}} : nq ? -cq : cq;
                rem <= zf ? raw : nr ? -cr : cr;
                err <= zf;
            end
        end
    end
    assign busy = (state != IDLE) || cbusy;
    div_iter_u #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (go && (|b)),
        .dnd   (am),
        .der   (bm),
        .busy  (cbusy),
        .done  (cdone),
        .quo   (cq),
        .rem   (cr)
    );
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed tests of div_sched against an arithmetic reference model
module tb_div_sched;
    localparam int W = 32;
    logic clk = 0;
    logic rst, req0, req1, sgn0, sgn1, ack0, ack1, done0, done1, err, busy;
    logic [W-1:0] dnd0, dnd1, der0, der1, quo, rem;
    int tests = 0, fails = 0, cyc = 0;
    typedef struct {bit port; logic [W-1:0] q; logic [W-1:0] r; bit e; int at; int due;} op_t;
    op_t sb[$];
    bit last = 1;

    div_sched dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .sgn0(sgn0), .sgn1(sgn1),
        .dnd0(dnd0), .dnd1(dnd1), .der0(der0), .der1(der1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .quo(quo), .rem(rem), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic op_t model(input bit p, input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        op_t o;
        longint x, y;
        o.port = p;
        o.e = 0;
        if (b == 0) begin
            o.q = '1; o.r = a; o.e = 1;
        end else if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
            o.q = W'(x / y);
            o.r = W'(x % y);
        end else begin
            o.q = a / b;
            o.r = a % b;
        end
        return o;
    endfunction

    // reference scoreboard: one operation in flight, fixed latency, round-robin grant
    initial begin
        bit infl, now, e0, e1, p;
        op_t o;
        forever begin
            @(negedge clk);
            infl = sb.size() > 0 && sb[0].at < cyc && cyc < sb[0].due;
            now  = sb.size() > 0 && sb[0].due == cyc;
            e0 = !infl && req0 && (!req1 || last);
            e1 = !infl && req1 && (!req0 || !last);
            if (!rst) begin
                chk("m_ack0", ack0, e0);
                chk("m_ack1", ack1, e1);
                chk("m_busy", busy, infl);
                chk("m_done0", done0, now && !sb[0].port);
                chk("m_done1", done1, now && sb[0].port);
                if (now) begin
                    chk("m_quo", quo, sb[0].q);
                    chk("m_rem", rem, sb[0].r);
                    chk("m_err", err, sb[0].e);
                end
            end
            if (now) void'(sb.pop_front());
            if (rst) begin
                sb.delete();
                last = 1;
            end else if (e0 || e1) begin
                p = e1;
                o = model(p, p ? sgn1 : sgn0, p ? dnd1 : dnd0, p ? der1 : der0);
                o.at = cyc;
                o.due = cyc + ((p ? der1 : der0) == 0 ? 2 : 34);
                sb.push_back(o);
                last = p;
            end
            cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive(input bit p, input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        if (p) begin sgn1 = s; dnd1 = a; der1 = b; req1 = 1; end
        else   begin sgn0 = s; dnd0 = a; der0 = b; req0 = 1; end
    endtask

    task automatic run_op(input string nm, input bit p, input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input bit ee, input int lat);
        int n = 0, nb = 0;
        bit got = 0, d = 0;
        drive(p, s, a, b);
        while (!got && n < 50) begin @(negedge clk); got = p ? ack1 : ack0; n++; end
        chk({nm, "_ack"}, got, 1);
        step(1);
        req0 = 0; req1 = 0;
        n = 0;
        while (!d && n < 60) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            d = p ? done1 : done0;
        end
        chk({nm, "_lat"}, n, lat);
        chk({nm, "_busycyc"}, nb, lat - 1);
        chk({nm, "_quo"}, quo, eq);
        chk({nm, "_rem"}, rem, er);
        chk({nm, "_err"}, err, ee);
        step(1);
    endtask

    task automatic do_reset;
        rst = 1;
        step(2);
        rst = 0;
    endtask

    initial begin
        int n, na;
        bit gp[3];
        bit seen;
        rst = 1; req0 = 0; req1 = 0; sgn0 = 0; sgn1 = 0;
        dnd0 = 0; dnd1 = 0; der0 = 0; der1 = 0;
        step(2);
        rst = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_quo", quo, 0);
        chk("rst_rem", rem, 0);
        chk("rst_err", err, 0);
        chk("rst_done", {done1, done0}, 0);
        step(1);

        run_op("udiv",  0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 34);
        run_op("sdiv",  1, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 34);
        run_op("sovf",  0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0, 34);
        run_op("div0",  1, 0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1, 2);
        run_op("sdiv0", 0, 1, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF0, 1, 2);
        run_op("sneg",  1, 1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0, 34);
        run_op("ubig",  0, 0, 32'hFFFFFFFF, 32'd10, 32'h19999999, 32'd5, 0, 34);

        do_reset;
        drive(0, 0, 32'd1000, 32'd3);
        drive(1, 1, 32'hFFFFFF9C, 32'd7);
        n = 0; na = 0;
        while (na < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (ack0 || ack1) begin
                gp[na] = ack1;
                if (na > 0) chk("rr_ack_with_done", gp[na-1] ? done1 : done0, 1);
                na++;
            end
        end
        chk("rr_acks", na, 3);
        chk("rr_g0", gp[0], 0);
        chk("rr_g1", gp[1], 1);
        chk("rr_g2", gp[2], 0);
        step(1);
        req0 = 0; req1 = 0;
        step(40);

        drive(0, 0, 32'd50, 32'd3);
        n = 0; seen = 0;
        while (!seen && n < 50) begin @(negedge clk); seen = ack0; n++; end
        chk("mr_ack", seen, 1);
        step(1);
        req0 = 0;
        step(9);
        rst = 1;
        step(1);
        rst = 0;
        @(negedge clk);
        chk("mr_busy", busy, 0);
        chk("mr_quo", quo, 0);
        chk("mr_rem", rem, 0);
        chk("mr_err", err, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done0 || done1) seen = 1;
        end
        chk("mr_no_done", seen, 0);
        step(1);
        run_op("fresh", 1, 0, 32'd50, 32'd3, 32'd16, 32'd2, 0, 34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
